// File: rtl/vie_dreq_stage_pkg.sv
// Shared definitions for the data-request stage: widths, op codes, FSM states, op classifiers.
package vie_dreq_stage_pkg;

   localparam int VRSBUS   = 83;
   localparam int VRSTATUS = 41;

   // Non-memory op codes (any code not listed below as load/store is non-memory)
   localparam logic [7:0] VIE_OP_NOP = 8'h00;
   localparam logic [7:0] VIE_OP_ADD = 8'h10;
   localparam logic [7:0] VIE_OP_OR  = 8'h11;

   // Loads
   localparam logic [7:0] VIE_OP_LB  = 8'h01;
   localparam logic [7:0] VIE_OP_LBU = 8'h02;
   localparam logic [7:0] VIE_OP_LH  = 8'h03;
   localparam logic [7:0] VIE_OP_LHU = 8'h04;
   localparam logic [7:0] VIE_OP_LW  = 8'h05;
   localparam logic [7:0] VIE_OP_LWL = 8'h06;
   localparam logic [7:0] VIE_OP_LWR = 8'h07;

   // Stores
   localparam logic [7:0] VIE_OP_SB  = 8'h08;
   localparam logic [7:0] VIE_OP_SH  = 8'h09;
   localparam logic [7:0] VIE_OP_SW  = 8'h0A;
   localparam logic [7:0] VIE_OP_SWL = 8'h0B;
   localparam logic [7:0] VIE_OP_SWR = 8'h0C;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } dreq_state_e;

   function automatic logic op_is_load(input logic [7:0] op);
      return (op inside {VIE_OP_LB, VIE_OP_LBU, VIE_OP_LH, VIE_OP_LHU,
                         VIE_OP_LW, VIE_OP_LWL, VIE_OP_LWR});
   endfunction

   function automatic logic op_is_store(input logic [7:0] op);
      return (op inside {VIE_OP_SB, VIE_OP_SH, VIE_OP_SW, VIE_OP_SWL, VIE_OP_SWR});
   endfunction

   function automatic logic op_is_mem(input logic [7:0] op);
      return op_is_load(op) | op_is_store(op);
   endfunction

   // LWL/LWR forward rt as fixres so MEM can merge the loaded bytes into it
   function automatic logic op_is_merge_load(input logic [7:0] op);
      return (op inside {VIE_OP_LWL, VIE_OP_LWR});
   endfunction

endpackage

// File: rtl/vie_store_align.sv
// Combinational store lane alignment: byte strobes, lane-placed data, access size, word-align select.
module vie_store_align
   import vie_dreq_stage_pkg::*;
(
   input  logic [7:0]  op,
   input  logic [1:0]  a,
   input  logic [31:0] rt,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [1:0]  size,
   output logic        word_align
);

   // Little-endian byte strobes and store data placed on the addressed lanes
   always_comb begin
      wstrb = 4'b0000;
      wdata = 32'h0000_0000;
      case (op)
         VIE_OP_SB: begin
            wdata = {4{rt[7:0]}};
            case (a)
               2'd0:    wstrb = 4'b0001;
               2'd1:    wstrb = 4'b0010;
               2'd2:    wstrb = 4'b0100;
               2'd3:    wstrb = 4'b1000;
               default: wstrb = 4'b0000;
            endcase
         end
         VIE_OP_SH: begin
            wdata = {2{rt[15:0]}};
            if (a[1]) begin
               wstrb = 4'b1100;
            end else begin
               wstrb = 4'b0011;
            end
         end
         VIE_OP_SW: begin
            wdata = rt;
            wstrb = 4'b1111;
         end
         VIE_OP_SWL: begin
            case (a)
               2'd0:    begin wstrb = 4'b0001; wdata = {24'h00_0000, rt[31:24]}; end
               2'd1:    begin wstrb = 4'b0011; wdata = {16'h0000, rt[31:16]};    end
               2'd2:    begin wstrb = 4'b0111; wdata = {8'h00, rt[31:8]};        end
               2'd3:    begin wstrb = 4'b1111; wdata = rt;                       end
               default: begin wstrb = 4'b0000; wdata = 32'h0000_0000;            end
            endcase
         end
         VIE_OP_SWR: begin
            case (a)
               2'd0:    begin wstrb = 4'b1111; wdata = rt;                       end
               2'd1:    begin wstrb = 4'b1110; wdata = {rt[23:0], 8'h00};        end
               2'd2:    begin wstrb = 4'b1100; wdata = {rt[15:0], 16'h0000};     end
               2'd3:    begin wstrb = 4'b1000; wdata = {rt[7:0], 24'h00_0000};   end
               default: begin wstrb = 4'b0000; wdata = 32'h0000_0000;            end
            endcase
         end
         default: begin
            wstrb = 4'b0000;
            wdata = 32'h0000_0000;
         end
      endcase
   end

   // Access size and whether the request address is forced to a word boundary
   always_comb begin
      size       = 2'd2;
      word_align = 1'b0;
      case (op)
         VIE_OP_LB, VIE_OP_LBU, VIE_OP_SB: size = 2'd0;
         VIE_OP_LH, VIE_OP_LHU, VIE_OP_SH: size = 2'd1;
         VIE_OP_LWL, VIE_OP_LWR, VIE_OP_SWL, VIE_OP_SWR: begin
            size       = 2'd2;
            word_align = 1'b1;
         end
         default: size = 2'd2;
      endcase
   end

endmodule

// File: rtl/vie_dreq_stage.sv
// Data-request stage: captures one instruction, issues the SRAM-like request, hands off to MEM.
module vie_dreq_stage
   import vie_dreq_stage_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                es_valid,
   output logic                es_allowin,
   input  logic [7:0]          es_op,
   input  logic [31:0]         es_res,
   input  logic [31:0]         es_rt,
   input  logic [6:0]          es_dest,
   input  logic [31:0]         es_pc,
   input  logic                ms_allowin,
   output logic [VRSBUS-1:0]   rsbus_o,
   output logic [31:0]         ifc_data_o,
   output logic [VRSTATUS-1:0] rstatus_o,
   output logic                data_req,
   output logic                data_wr,
   output logic [1:0]          data_size,
   output logic [31:0]         data_addr,
   output logic [3:0]          data_wstrb,
   output logic [31:0]         data_wdata,
   input  logic                data_addr_ok,
   input  logic                data_data_ok,
   input  logic [31:0]         data_rdata
);

   dreq_state_e state_q, state_d;

   logic [7:0]  op_q,   op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] rt_q,   rt_d;
   logic [6:0]  dest_q, dest_d;
   logic [31:0] pc_q,   pc_d;
   logic [31:0] rbuf_q, rbuf_d;
   logic [31:0] ifc_q,  ifc_d;

   logic        accept;
   logic        handoff;
   logic        mem_done;
   logic        out_valid;
   logic        busy;
   logic        is_load;
   logic [31:0] fixres;
   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata;
   logic [1:0]  al_size;
   logic        al_word_align;

   vie_store_align u_store_align (
      .op         (op_q),
      .a          (addr_q[1:0]),
      .rt         (rt_q),
      .wstrb      (al_wstrb),
      .wdata      (al_wdata),
      .size       (al_size),
      .word_align (al_word_align)
   );

   assign accept   = es_valid & es_allowin;
   assign handoff  = (state_q == ST_DONE) & ms_allowin;
   assign mem_done = ((state_q == ST_REQ) & data_addr_ok & data_data_ok) |
                     ((state_q == ST_WAIT) & data_data_ok);

   // State register
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; data_ok outside an outstanding request is ignored
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = op_is_mem(es_op) ? ST_REQ : ST_DONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (data_addr_ok) begin
               state_d = data_data_ok ? ST_DONE : ST_WAIT;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (data_data_ok) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_DONE: begin
            if (accept) begin
               state_d = op_is_mem(es_op) ? ST_REQ : ST_DONE;
            end else if (ms_allowin) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State-decoded control outputs
   always_comb begin
      es_allowin = 1'b0;
      data_req   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      case (state_q)
         ST_IDLE: begin
            es_allowin = 1'b1;
            busy       = 1'b0;
         end
         ST_REQ:  data_req = 1'b1;
         ST_WAIT: data_req = 1'b0;
         ST_DONE: begin
            es_allowin = ms_allowin;
            out_valid  = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

   // Capture registers, load buffer and MEM-facing load word next values
   always_comb begin
      op_d   = op_q;
      addr_d = addr_q;
      rt_d   = rt_q;
      dest_d = dest_q;
      pc_d   = pc_q;
      if (accept) begin
         op_d   = es_op;
         addr_d = es_res;
         rt_d   = es_rt;
         dest_d = es_dest;
         pc_d   = es_pc;
      end else begin
         op_d   = op_q;
      end
      if (mem_done && op_is_load(op_q)) begin
         rbuf_d = data_rdata;
      end else begin
         rbuf_d = rbuf_q;
      end
      // MEM only sees the new word once it takes the instruction, so a stall keeps it stable
      if (handoff) begin
         ifc_d = rbuf_q;
      end else begin
         ifc_d = ifc_q;
      end
   end

   // Capture, rbuf and ifc registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         op_q   <= 8'h00;
         addr_q <= 32'h0000_0000;
         rt_q   <= 32'h0000_0000;
         dest_q <= 7'h00;
         pc_q   <= 32'h0000_0000;
         rbuf_q <= 32'h0000_0000;
         ifc_q  <= 32'h0000_0000;
      end else begin
         op_q   <= op_d;
         addr_q <= addr_d;
         rt_q   <= rt_d;
         dest_q <= dest_d;
         pc_q   <= pc_d;
         rbuf_q <= rbuf_d;
         ifc_q  <= ifc_d;
      end
   end

   assign is_load = op_is_load(op_q);
   assign fixres  = op_is_merge_load(op_q) ? rt_q : addr_q;

   assign data_wr    = data_req & op_is_store(op_q);
   assign data_size  = al_size;
   assign data_addr  = al_word_align ? {addr_q[31:2], 2'b00} : addr_q;
   assign data_wstrb = al_wstrb;
   assign data_wdata = al_wdata;

   assign rsbus_o    = {out_valid, is_load, op_q, addr_q[1:0], dest_q, fixres, pc_q};
   assign rstatus_o  = {busy, is_load, dest_q, fixres};
   assign ifc_data_o = ifc_q;

endmodule

// File: tb/tb_vie_dreq_stage.sv
// Randomized bench for vie_dreq_stage checked against a transaction-level reference model.
module tb_vie_dreq_stage;
   import vie_dreq_stage_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        es_valid;
   logic        es_allowin;
   logic [7:0]  es_op;
   logic [31:0] es_res;
   logic [31:0] es_rt;
   logic [6:0]  es_dest;
   logic [31:0] es_pc;
   logic        ms_allowin;
   logic [82:0] rsbus_o;
   logic [31:0] ifc_data_o;
   logic [40:0] rstatus_o;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   int checks   = 0;
   int failures = 0;

   // Reference state: last captured load word and the word MEM currently sees
   logic [31:0] m_rbuf = 32'h0;
   logic [31:0] m_ifc  = 32'h0;

   logic [7:0] op_tab [14] = '{VIE_OP_LB, VIE_OP_LBU, VIE_OP_LH, VIE_OP_LHU, VIE_OP_LW,
                               VIE_OP_LWL, VIE_OP_LWR, VIE_OP_SB, VIE_OP_SH, VIE_OP_SW,
                               VIE_OP_SWL, VIE_OP_SWR, VIE_OP_ADD, VIE_OP_OR};

   vie_dreq_stage dut (
      .clock        (clock),
      .reset        (reset),
      .es_valid     (es_valid),
      .es_allowin   (es_allowin),
      .es_op        (es_op),
      .es_res       (es_res),
      .es_rt        (es_rt),
      .es_dest      (es_dest),
      .es_pc        (es_pc),
      .ms_allowin   (ms_allowin),
      .rsbus_o      (rsbus_o),
      .ifc_data_o   (ifc_data_o),
      .rstatus_o    (rstatus_o),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wstrb   (data_wstrb),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [82:0] act, input logic [82:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic ref_load(input logic [7:0] op);
      return op inside {VIE_OP_LB, VIE_OP_LBU, VIE_OP_LH, VIE_OP_LHU, VIE_OP_LW, VIE_OP_LWL, VIE_OP_LWR};
   endfunction

   function automatic logic ref_store(input logic [7:0] op);
      return op inside {VIE_OP_SB, VIE_OP_SH, VIE_OP_SW, VIE_OP_SWL, VIE_OP_SWR};
   endfunction

   function automatic logic [3:0] ref_strb(input logic [7:0] op, input logic [1:0] a);
      int s = int'(a);
      case (op)
         VIE_OP_SB:  return 4'(1 << s);
         VIE_OP_SH:  return 4'(3 << s);
         VIE_OP_SW:  return 4'hF;
         VIE_OP_SWL: return 4'((1 << (s + 1)) - 1);
         VIE_OP_SWR: return 4'((15 << s) & 15);
         default:    return 4'h0;
      endcase
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [7:0] op, input logic [1:0] a, input logic [31:0] rt);
      int s = int'(a);
      case (op)
         VIE_OP_SB:  return {24'h0, rt[7:0]} * 32'h0101_0101;
         VIE_OP_SH:  return {16'h0, rt[15:0]} * 32'h0001_0001;
         VIE_OP_SW:  return rt;
         VIE_OP_SWL: return rt >> (8 * (3 - s));
         VIE_OP_SWR: return rt << (8 * s);
         default:    return 32'h0;
      endcase
   endfunction

   function automatic logic [1:0] ref_size(input logic [7:0] op);
      if (op inside {VIE_OP_LB, VIE_OP_LBU, VIE_OP_SB}) return 2'd0;
      if (op inside {VIE_OP_LH, VIE_OP_LHU, VIE_OP_SH}) return 2'd1;
      return 2'd2;
   endfunction

   function automatic logic [31:0] ref_addr(input logic [7:0] op, input logic [31:0] addr);
      if (op inside {VIE_OP_LWL, VIE_OP_LWR, VIE_OP_SWL, VIE_OP_SWR}) return addr & 32'hFFFF_FFFC;
      return addr;
   endfunction

   function automatic logic [31:0] ref_fix(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt);
      if (op == VIE_OP_LWL || op == VIE_OP_LWR) return rt;
      return addr;
   endfunction

   task automatic check_req(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt);
      check_val("data_req",   83'(data_req),   83'(1'b1));
      check_val("data_wr",    83'(data_wr),    83'(ref_store(op)));
      check_val("data_size",  83'(data_size),  83'(ref_size(op)));
      check_val("data_addr",  83'(data_addr),  83'(ref_addr(op, addr)));
      check_val("data_wstrb", 83'(data_wstrb), 83'(ref_strb(op, addr[1:0])));
      check_val("data_wdata", 83'(data_wdata), 83'(ref_wdata(op, addr[1:0], rt)));
      check_val("busy_allowin", 83'(es_allowin), 83'(1'b0));
   endtask

   task automatic check_done(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                             input logic [6:0] dest, input logic [31:0] pc);
      logic [31:0] fx;
      fx = ref_fix(op, addr, rt);
      check_val("rsbus",   83'(rsbus_o),   {1'b1, ref_load(op), op, addr[1:0], dest, fx, pc});
      check_val("rstatus", 83'(rstatus_o), 83'({1'b1, ref_load(op), dest, fx}));
      check_val("done_req", 83'(data_req), 83'(1'b0));
   endtask

   // One instruction from IDLE to handoff. ad: addr_ok delay, wd: data_ok delay after
   // address, same: addr_ok and data_ok together, stall: cycles of ms_allowin=0 in DONE.
   task automatic do_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                         input logic [6:0] dest, input logic [31:0] pc, input int ad, input int wd,
                         input bit same, input int stall, input logic [31:0] rdata);
      check_val("idle_allowin", 83'(es_allowin), 83'(1'b1));
      es_valid = 1'b1; es_op = op; es_res = addr; es_rt = rt; es_dest = dest; es_pc = pc;
      ms_allowin = (stall == 0);
      @(negedge clock);
      es_valid = 1'b0; es_op = op_tab[$urandom_range(0, 13)];
      es_res = $urandom; es_rt = $urandom; es_dest = 7'($urandom); es_pc = $urandom;
      if (ref_load(op) || ref_store(op)) begin
         for (int i = 0; i <= ad; i++) begin
            check_req(op, addr, rt);
            check_val("req_valid", 83'(rsbus_o[82]), 83'(1'b0));
            if (i == ad) begin
               data_addr_ok = 1'b1; data_data_ok = same; data_rdata = rdata;
            end else begin
               data_addr_ok = 1'b0; data_data_ok = 1'($urandom_range(0, 1)); data_rdata = $urandom;
            end
            @(negedge clock);
         end
         data_addr_ok = 1'b0; data_data_ok = 1'b0;
         if (!same) begin
            for (int i = 0; i <= wd; i++) begin
               check_val("wait_req",   83'(data_req),     83'(1'b0));
               check_val("wait_valid", 83'(rsbus_o[82]),  83'(1'b0));
               check_val("wait_busy",  83'(rstatus_o[40]), 83'(1'b1));
               data_data_ok = (i == wd);
               data_rdata   = (i == wd) ? rdata : $urandom;
               @(negedge clock);
            end
            data_data_ok = 1'b0;
         end
         if (ref_load(op)) m_rbuf = rdata;
      end
      for (int i = 0; i <= stall; i++) begin
         ms_allowin   = (i == stall);
         data_data_ok = (i < stall) ? 1'($urandom_range(0, 1)) : 1'b0;
         data_rdata   = $urandom;
         #1;
         check_done(op, addr, rt, dest, pc);
         check_val("ifc_hold",    83'(ifc_data_o), 83'(m_ifc));
         check_val("done_allowin", 83'(es_allowin), 83'(i == stall));
         @(negedge clock);
      end
      m_ifc = m_rbuf;
      data_data_ok = 1'b0; ms_allowin = 1'b1;
      check_val("ifc_handoff", 83'(ifc_data_o),    83'(m_ifc));
      check_val("post_valid",  83'(rsbus_o[82]),   83'(1'b0));
      check_val("post_busy",   83'(rstatus_o[40]), 83'(1'b0));
   endtask

   initial begin
      logic [7:0]  b_op   [3];
      logic [31:0] b_res  [3];
      logic [31:0] b_rt   [3];
      logic [6:0]  b_dest [3];
      logic [31:0] b_pc   [3];
      logic [7:0]  op;
      logic [31:0] addr;

      reset = 1'b0; es_valid = 1'b0; es_op = 8'h00; es_res = 32'h0; es_rt = 32'h0;
      es_dest = 7'h0; es_pc = 32'h0; ms_allowin = 1'b1;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
      repeat (3) @(negedge clock);
      check_val("rst_req",     83'(data_req),    83'(1'b0));
      check_val("rst_wr",      83'(data_wr),     83'(1'b0));
      check_val("rst_valid",   83'(rsbus_o[82]), 83'(1'b0));
      check_val("rst_ifc",     83'(ifc_data_o),  83'(32'h0));
      check_val("rst_rstatus", 83'(rstatus_o),   83'(41'h0));
      check_val("rst_allowin", 83'(es_allowin),  83'(1'b1));
      reset = 1'b1;
      @(negedge clock);

      // Directed store/load cases
      do_txn(VIE_OP_SW,  32'h0000_1000, 32'hA1B2_C3D4, 7'd5,  32'h0040_0000, 0, 0, 1'b0, 0, 32'h0);
      do_txn(VIE_OP_SB,  32'h0000_2002, 32'h0000_00EE, 7'd6,  32'h0040_0004, 0, 0, 1'b0, 0, 32'h0);
      do_txn(VIE_OP_SH,  32'h0000_3002, 32'h0000_1234, 7'd7,  32'h0040_0008, 1, 0, 1'b1, 0, 32'h0);
      do_txn(VIE_OP_SWL, 32'h0000_4001, 32'h1122_3344, 7'd8,  32'h0040_000C, 0, 1, 1'b0, 1, 32'h0);
      do_txn(VIE_OP_SWR, 32'h0000_4003, 32'h1122_3344, 7'd9,  32'h0040_0010, 0, 0, 1'b0, 0, 32'h0);
      do_txn(VIE_OP_LW,  32'h0000_5000, 32'h0000_0000, 7'd10, 32'h0040_0014, 3, 0, 1'b0, 2, 32'hCAFE_F00D);
      do_txn(VIE_OP_LWL, 32'h0000_6002, 32'h5566_7788, 7'd11, 32'h0040_0018, 0, 0, 1'b1, 0, 32'h1357_9BDF);

      // Three ALU ops back to back: one handoff per cycle, N+1 latency
      for (int k = 0; k < 3; k++) begin
         b_op[k] = (k == 1) ? VIE_OP_OR : VIE_OP_ADD;
         b_res[k] = $urandom; b_rt[k] = $urandom; b_dest[k] = 7'($urandom); b_pc[k] = $urandom;
      end
      ms_allowin = 1'b1;
      for (int k = 0; k <= 3; k++) begin
         if (k > 0) begin
            check_done(b_op[k-1], b_res[k-1], b_rt[k-1], b_dest[k-1], b_pc[k-1]);
            check_val("b2b_allowin", 83'(es_allowin), 83'(1'b1));
         end
         if (k < 3) begin
            es_valid = 1'b1; es_op = b_op[k]; es_res = b_res[k]; es_rt = b_rt[k];
            es_dest = b_dest[k]; es_pc = b_pc[k];
         end else begin
            es_valid = 1'b0;
         end
         @(negedge clock);
      end
      m_ifc = m_rbuf;
      check_val("b2b_end_valid", 83'(rsbus_o[82]), 83'(1'b0));
      check_val("b2b_ifc",       83'(ifc_data_o),  83'(m_ifc));

      // Reset while WAIT, then a stray data_ok for the abandoned load
      es_valid = 1'b1; es_op = VIE_OP_LW; es_res = 32'h0000_7000; es_rt = 32'h0; es_dest = 7'd3; es_pc = 32'h0;
      @(negedge clock);
      es_valid = 1'b0; data_addr_ok = 1'b1;
      @(negedge clock);
      data_addr_ok = 1'b0; reset = 1'b0;
      @(negedge clock);
      m_rbuf = 32'h0; m_ifc = 32'h0;
      check_val("rstw_req",     83'(data_req),   83'(1'b0));
      check_val("rstw_rstatus", 83'(rstatus_o),  83'(41'h0));
      check_val("rstw_ifc",     83'(ifc_data_o), 83'(32'h0));
      reset = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
      @(negedge clock);
      data_data_ok = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check_val("stray_valid", 83'(rsbus_o[82]),   83'(1'b0));
         check_val("stray_busy",  83'(rstatus_o[40]), 83'(1'b0));
         check_val("stray_ifc",   83'(ifc_data_o),    83'(32'h0));
         check_val("stray_req",   83'(data_req),      83'(1'b0));
         @(negedge clock);
      end

      // Randomized instruction stream
      for (int n = 0; n < 60; n++) begin
         op   = op_tab[$urandom_range(0, 13)];
         addr = $urandom;
         if (op inside {VIE_OP_LH, VIE_OP_LHU, VIE_OP_SH}) addr[0] = 1'b0;
         if (op inside {VIE_OP_LW, VIE_OP_SW}) addr[1:0] = 2'b00;
         do_txn(op, addr, $urandom, 7'($urandom), $urandom, $urandom_range(0, 3),
                $urandom_range(0, 2), ($urandom_range(0, 3) == 0), $urandom_range(0, 2), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vie_dreq_stage.md
# vie_dreq_stage

Data-request stage between execute and `vie_mem_stage`: the initiating side of the data-SRAM load/store interface. Accepts one memory or non-memory instruction at a time and issues an SRAM-like request with byte strobes and lane-aligned store data. It waits for the address and data handshakes, then hands the instruction plus the captured load word to the MEM stage on its rsbus/ifc_data inputs.

## Interface
- Parameters: none. Widths come from shared defines: `Vrsbus`=83, `Vrstatus`=41.
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-low (0 = reset).
- `es_valid` in 1: upstream instruction valid.
- `es_allowin` out 1: stage can accept this cycle.
- `es_op` in 8: `VIE_OP_*` code.
- `es_res` in 32: ALU result; the byte address for memory ops.
- `es_rt` in 32: rt value (store data / lwl/lwr merge source).
- `es_dest` in 7: destination register tag.
- `es_pc` in 32.
- `ms_allowin` in 1: MEM stage accepts.
- `rsbus_o` out 83: {valid[82], res_from_mem[81], op[80:73], sel[72:71], dest[70:64], fixres[63:32], pc[31:0]}.
- `ifc_data_o` out 32: load word for the instruction currently held by MEM.
- `rstatus_o` out 41: {busy, res_from_mem, dest, fixres} for hazard/forwarding.
- `data_req` out 1, `data_wr` out 1, `data_size` out 2, `data_addr` out 32, `data_wstrb` out 4, `data_wdata` out 32.
- `data_addr_ok` in 1, `data_data_ok` in 1, `data_rdata` in 32.

## Operation
- Memory op: any load (LB, LBU, LH, LHU, LW, LWL, LWR) or store (SB, SH, SW, SWL, SWR).
- FSM states:
  - IDLE: empty.
  - REQ: `data_req`=1.
  - WAIT: address accepted.
  - DONE: result held.
- `es_allowin` = IDLE | (DONE & `ms_allowin`).
- Accept when `es_valid & es_allowin`. Capture op, addr=`es_res`, rt, dest, pc.
  - Memory op → REQ.
  - Otherwise → DONE.
  - No accept from DONE → IDLE.
- REQ:
  - `addr_ok` → WAIT.
  - `addr_ok` & `data_ok` in the same cycle → DONE.
- WAIT: `data_ok` → DONE. Capture `data_rdata` into rbuf on loads.
- `data_ok` is ignored in IDLE, REQ-without-`addr_ok`, and DONE.
- Request fields stay stable while `data_req`=1. `data_wr`=1 for stores.
- `sel` = addr[1:0] = a.
- `data_addr`: addr for B/H/W ops; {addr[31:2],2'b00} for LWL/LWR/SWL/SWR.
- `data_size`: 0 for byte ops, 1 for half, 2 for word/LWL/LWR/SWL/SWR.
- Write strobes and data (little-endian):
  - SB: wstrb = 1<<a, wdata = {4{rt[7:0]}}.
  - SH: a=0 → 0011, a=2 → 1100; wdata = {2{rt[15:0]}}.
  - SW: 1111, wdata = rt.
  - SWL: a=0 → 0001 {24'b0,rt[31:24]}; a=1 → 0011 {16'b0,rt[31:16]}; a=2 → 0111 {8'b0,rt[31:8]}; a=3 → 1111 rt.
  - SWR: a=0 → 1111 rt; a=1 → 1110 {rt[23:0],8'b0}; a=2 → 1100 {rt[15:0],16'b0}; a=3 → 1000 {rt[7:0],24'b0}.
  - Loads: wstrb=0000, wdata=0.
- Alignment faults are not checked here.
- `rsbus_o` fields:
  - valid = DONE.
  - res_from_mem = load.
  - fixres = rt for LWL/LWR, else `es_res`.
- `ifc_data_o` loads rbuf on the handoff cycle (DONE & `ms_allowin`). It holds that value until the next handoff, so MEM sees a stable word while stalled.
- `rstatus_o` busy = state≠IDLE.

## Timing
- Reset values: state IDLE, `data_req`=0, `data_wr`=0, `rsbus_o[82]`=0, `ifc_data_o`=0, rbuf=0, `rstatus_o`=0. `es_allowin`=1 after reset.
- Non-memory op accepted at cycle N: `rsbus_o` valid at N+1.
- Memory op accepted at N:
  - `data_req` from N+1.
  - Zero-wait slave (`addr_ok` at N+1, `data_ok` at N+2): valid at N+3.
  - `addr_ok` & `data_ok` both at N+1: valid at N+2.
- Back-to-back throughput: one non-memory op per cycle. Memory ops: at most one outstanding; the next request issues no earlier than the cycle after the handoff.
- `ms_allowin`=0 in DONE: hold all outputs, `es_allowin`=0, no new request.
- Reset mid-REQ/WAIT: IDLE next cycle, `data_req` drops. A later `data_ok` for the abandoned request is dropped.

## Structure
- Shared defines header: `VIE_OP_*` codes, `Vrsbus`, `Vrstatus`, state encodings.
- Sub-module `vie_store_align`: combinational (op, a, rt) → (wstrb, wdata, size, aligned-addr select).
- FSM, capture registers and rbuf/`ifc_data_o` live in the top.

## Test plan
- SW, addr 0x1000, rt 0xA1B2C3D4, `addr_ok`@N+1, `data_ok`@N+2 → `data_wstrb`=1111, `data_wdata`=0xA1B2C3D4, `data_wr`=1; `rsbus_o` valid @N+3, res_from_mem=0.
- SB a=2, rt 0x000000EE → wstrb 0100, wdata 0xEEEEEEEE, size 0. SH a=2, rt 0x1234 → 1100, 0x12341234, size 1.
- SWL a=1, rt 0x11223344 → wstrb 0011, wdata 0x00001122, addr word-aligned. SWR a=3 → wstrb 1000, wdata 0x44000000.
- LW, `addr_ok` delayed 3 cycles, `data_rdata`=0xCAFEF00D, `ms_allowin`=0 for 2 cycles after DONE → `data_req` held stable; `es_allowin`=0; `ifc_data_o` becomes 0xCAFEF00D only at handoff and holds after.
- Three ALU ops back-to-back with `ms_allowin`=1 → one `rsbus_o` valid per cycle, N+1 latency, fixres=`es_res`.
- `reset`=0 while in WAIT, then `data_ok` pulse after release → state IDLE, no `rsbus_o` valid, `ifc_data_o`=0.
